// File: rtl/user_bp_dir_seq.sv
// user_bp_dir_seq
// Backplane direction sequencer. Sits between the CPU-written backplane
// direction/output registers and the pad drivers. Direction changes are
// applied break-before-make: a pin drops to input one cycle after its request
// falls, but a pin only becomes an output after a programmable dead time. This
// avoids drive contention with the partner card during bus turnaround.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active-low
//   req_dir      requested direction per pin, 1 = drive
//   req_out      requested output level per pin
//   force_in     emergency release, all pins input while high
//   bp_dir       applied direction to pad drivers, 1 = drive
//   bp_out       output level to pad drivers (1-cycle register of req_out)
//   busy         high while an engagement is pending (state != IDLE)
//   engage_pulse one-cycle pulse in the cycle after an engagement is applied
module user_bp_dir_seq #(
    parameter int nr_backplane_ios = 16,
    parameter int dead_cycles      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [nr_backplane_ios-1:0] req_dir,
    input  logic [nr_backplane_ios-1:0] req_out,
    input  logic                        force_in,
    output logic [nr_backplane_ios-1:0] bp_dir,
    output logic [nr_backplane_ios-1:0] bp_out,
    output logic                        busy,
    output logic                        engage_pulse
);

    localparam int cnt_width = $clog2(dead_cycles + 1);
    localparam logic [cnt_width-1:0] dead_load = cnt_width'(dead_cycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        ENGAGE
    } state_t;

    state_t                        state_reg;
    state_t                        state_next;
    logic [cnt_width-1:0]          counter_reg;
    logic [cnt_width-1:0]          counter_next;
    logic [nr_backplane_ios-1:0]   target_reg;
    logic [nr_backplane_ios-1:0]   target_next;
    logic [nr_backplane_ios-1:0]   dir_reg;
    logic [nr_backplane_ios-1:0]   dir_next;
    logic [nr_backplane_ios-1:0]   out_reg;
    logic [nr_backplane_ios-1:0]   eng_mask;
    logic [nr_backplane_ios-1:0]   eng;
    // applied_reg marks the edge on which ENGAGE took effect; the pulse is
    // emitted one cycle later from it.
    logic                          applied_reg;
    logic                          applied_next;
    logic                          pulse_reg;
    logic                          pulse_next;

    // Pins requested as output that are not yet driven.
    assign eng = req_dir & ~dir_reg;

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        target_next  = target_reg;
        applied_next = 1'b0;
        eng_mask     = '0;

        case (state_reg)
            IDLE: begin
                if (|eng) begin
                    target_next  = eng;
                    counter_next = dead_load;
                    state_next   = DEAD;
                end
            end
            DEAD: begin
                // Requests arriving now are deliberately not merged into
                // target; they get their own full dead time from IDLE.
                if (counter_reg == '0) begin
                    state_next = ENGAGE;
                end else begin
                    counter_next = counter_reg - cnt_width'(1);
                end
            end
            ENGAGE: begin
                eng_mask     = target_reg;
                applied_next = 1'b1;
                target_next  = '0;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (force_in) begin
            state_next   = IDLE;
            counter_next = '0;
            target_next  = '0;
            applied_next = 1'b0;
            eng_mask     = '0;
        end
    end

    // A pin is driven next cycle only if it is still requested; this both
    // releases dropped pins immediately and stops withdrawn target bits from
    // engaging.
    generate
        for (genvar gi = 0; gi < nr_backplane_ios; gi++) begin : g_pin
            assign dir_next[gi] = ~force_in & req_dir[gi] & (dir_reg[gi] | eng_mask[gi]);
        end
    endgenerate

    assign pulse_next = applied_reg & ~force_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            target_reg  <= '0;
            dir_reg     <= '0;
            out_reg     <= '0;
            applied_reg <= 1'b0;
            pulse_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            target_reg  <= target_next;
            dir_reg     <= dir_next;
            out_reg     <= req_out;
            applied_reg <= applied_next;
            pulse_reg   <= pulse_next;
        end
    end

    assign bp_dir       = dir_reg;
    assign bp_out       = out_reg;
    assign busy         = (state_reg != IDLE);
    assign engage_pulse = pulse_reg;

endmodule
